// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch program-counter generator.
// Alignment helpers work on 64-bit values so any XLEN up to 64 can use them.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        HOLD,
        FLUSH,
        REDIR,
        CALL,
        RET,
        SEQ
    } pc_sel_e;

    function automatic logic [63:0] low_mask(input int bits);
        return (64'd1 << bits) - 64'd1;
    endfunction

    function automatic logic [63:0] align_target(input logic [63:0] target, input int bits);
        return target & ~low_mask(bits);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control/redirect inputs and fetch outputs of pc_gen, bundled for the IF stage.
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    // There is no ready back to ID: a request is taken on the edge where no
    // higher-priority source and no stall is present, otherwise ID keeps it asserted.
    logic            start_i;
    logic            hazard_i;
    logic            hold_i;
    logic            halt_i;
    logic            flush_i;
    logic [XLEN-1:0] flush_pc_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            call_i;
    logic [XLEN-1:0] call_pc_i;
    logic            ret_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic [CW-1:0]   ras_count_o;
    logic            ras_miss_o;
    logic            misalign_o;

    modport master (
        output start_i, hazard_i, hold_i, halt_i, flush_i, flush_pc_i,
               redirect_i, redirect_pc_i, call_i, call_pc_i, ret_i,
        input  pc_o, pc_valid_o, ras_count_o, ras_miss_o, misalign_o
    );

    modport slave (
        input  start_i, hazard_i, hold_i, halt_i, flush_i, flush_pc_i,
               redirect_i, redirect_pc_i, call_i, call_pc_i, ret_i,
        output pc_o, pc_valid_o, ras_count_o, ras_miss_o, misalign_o
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop reads the entry at the top pointer, clear only empties the count.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [XLEN-1:0]            push_data_i,
    output logic [XLEN-1:0]            top_o,
    output logic [$clog2(RAS_DEPTH):0] count_o
);
    localparam int            PW   = $clog2(RAS_DEPTH);
    localparam logic [PW:0]   FULL = (PW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [PW:0]     count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        do_push = push_i && !clear_i;
        do_pop  = pop_i && !push_i && !clear_i && (count_q != '0);
        if (clear_i) begin
            count_d = '0;
        end else if (do_push) begin
            // The pointer wraps freely; on a full stack this lands on the oldest entry.
            top_d = top_q + PW'(1);
            if (count_q != FULL) count_d = count_q + (PW+1)'(1);
        end else if (do_pop) begin
            top_d   = top_q - PW'(1);
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[top_d] <= push_data_i;
    end

    assign top_o   = mem_q[top_q];
    assign count_o = count_q;
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: IDLE/RUN/HALT control, prioritised next-PC select and
// the PC register; every output is registered.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              INST_BYTES = 4,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    pc_gen_if.slave   bus,
    output pc_state_e state_o
);
    localparam int              ALIGN_BITS = $clog2(INST_BYTES);
    localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);

    pc_state_e                  state_q, state_d;
    pc_sel_e                    sel;
    logic [XLEN-1:0]            pc_q, pc_d, pc_seq, target;
    logic                       valid_q, miss_q, miss_d, mis_q, mis_d;
    logic                       load, stall, ras_empty;
    logic                       ras_push, ras_pop, ras_clear;
    logic [XLEN-1:0]            ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_count;

    assign pc_seq    = pc_q + INC;
    assign stall     = !bus.start_i || bus.hazard_i || bus.hold_i;
    assign ras_empty = (ras_count == '0);

    always_comb begin
        state_d = state_q;
        sel     = HOLD;
        case (state_q)
            IDLE: if (bus.start_i) state_d = RUN;
            RUN: begin
                // Halt outranks stalls and ID requests; the PC freezes where it is.
                if (bus.flush_i)         sel = FLUSH;
                else if (bus.halt_i)     state_d = HALT;
                else if (stall)          sel = HOLD;
                else if (bus.redirect_i) sel = REDIR;
                else if (bus.call_i)     sel = CALL;
                else if (bus.ret_i)      sel = RET;
                else                     sel = SEQ;
            end
            HALT: begin
                if (bus.flush_i) begin
                    state_d = RUN;
                    sel     = FLUSH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        target    = pc_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        miss_d    = 1'b0;
        case (sel)
            FLUSH: begin
                target    = bus.flush_pc_i;
                ras_clear = 1'b1;
            end
            REDIR: target = bus.redirect_pc_i;
            CALL: begin
                target   = bus.call_pc_i;
                ras_push = 1'b1;
            end
            RET: begin
                if (ras_empty) begin
                    target = pc_seq;
                    miss_d = 1'b1;
                end else begin
                    target  = ras_top;
                    ras_pop = 1'b1;
                end
            end
            SEQ:     target = pc_seq;
            default: target = pc_q;
        endcase
        load  = sel inside {FLUSH, REDIR, CALL};
        mis_d = load && ((64'(target) & low_mask(ALIGN_BITS)) != 64'd0);
        pc_d  = load ? XLEN'(align_target(64'(target), ALIGN_BITS)) : target;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            miss_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == RUN);
            miss_q  <= miss_d;
            mis_q   <= mis_d;
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .clear_i     (ras_clear),
        .push_data_i (pc_seq),
        .top_o       (ras_top),
        .count_o     (ras_count)
    );

    assign bus.pc_o        = pc_q;
    assign bus.pc_valid_o  = valid_q;
    assign bus.ras_count_o = ras_count;
    assign bus.ras_miss_o  = miss_q;
    assign bus.misalign_o  = mis_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a directed vector table with hand-derived expectations,
// then random traffic checked against a queue-based reference model.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam logic [31:0] RESET_VEC = 32'h100;
    localparam logic [8:0] RS = 9'h100, ST = 9'h080, HZ = 9'h040, HD = 9'h020, HT = 9'h010,
                           FL = 9'h008, RD = 9'h004, CL = 9'h002, RT = 9'h001;

    typedef struct {
        logic [8:0]  ctl;
        logic [31:0] ft;
        logic [31:0] t;
        logic [31:0] exp_pc;
        logic        exp_v;
        logic [2:0]  exp_cnt;
        logic        exp_miss;
        logic        exp_mis;
        pc_state_e   exp_st;
    } vec_t;

    logic      clk = 1'b0;
    logic      rst;
    pc_state_e state;
    int        n_tests = 0;
    int        n_fail  = 0;
    vec_t      vecs[$];
    logic [37:0] exp_q[$];

    pc_state_e   m_state;
    logic [31:0] m_pc;
    logic        m_valid, m_miss, m_mis;
    logic [31:0] m_ras[$];

    pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

    pc_gen #(
        .XLEN       (32),
        .RESET_VEC  (RESET_VEC),
        .INST_BYTES (4),
        .RAS_DEPTH  (4)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;

    function automatic bit has(input logic [8:0] c, input logic [8:0] m);
        return (c & m) != 9'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [8:0] ctl, input logic [31:0] ft, input logic [31:0] t,
                       input logic [31:0] pc, input logic v, input logic [2:0] cnt,
                       input logic miss, input logic mis, input pc_state_e st);
        vec_t r;
        r.ctl = ctl; r.ft = ft; r.t = t; r.exp_pc = pc; r.exp_v = v;
        r.exp_cnt = cnt; r.exp_miss = miss; r.exp_mis = mis; r.exp_st = st;
        vecs.push_back(r);
    endtask

    // Reference model: a plain queue as the stack, oldest entry dropped on overflow.
    task automatic load(input logic [31:0] t);
        m_mis = (t % 4) != 0;
        m_pc  = t - (t % 4);
    endtask

    task automatic model_step(input vec_t v);
        logic [31:0] seq;
        seq    = m_pc + 32'd4;
        m_miss = 1'b0;
        m_mis  = 1'b0;
        if (has(v.ctl, RS)) begin
            m_state = IDLE; m_pc = RESET_VEC; m_ras.delete();
        end else if (m_state == IDLE) begin
            if (has(v.ctl, ST)) m_state = RUN;
        end else if (m_state == HALT) begin
            if (has(v.ctl, FL)) begin m_state = RUN; m_ras.delete(); load(v.ft); end
        end else if (has(v.ctl, FL)) begin
            m_ras.delete(); load(v.ft);
        end else if (has(v.ctl, HT)) begin
            m_state = HALT;
        end else if (!has(v.ctl, ST) || has(v.ctl, HZ) || has(v.ctl, HD)) begin
            m_pc = m_pc;
        end else if (has(v.ctl, RD)) begin
            load(v.t);
        end else if (has(v.ctl, CL)) begin
            m_ras.push_back(seq);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
            load(v.t);
        end else if (has(v.ctl, RT)) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = seq; m_miss = 1'b1; end
        end else begin
            m_pc = seq;
        end
        m_valid = (m_state == RUN);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst               = has(v.ctl, RS);
        bus.start_i       = has(v.ctl, ST);
        bus.hazard_i      = has(v.ctl, HZ);
        bus.hold_i        = has(v.ctl, HD);
        bus.halt_i        = has(v.ctl, HT);
        bus.flush_i       = has(v.ctl, FL);
        bus.redirect_i    = has(v.ctl, RD);
        bus.call_i        = has(v.ctl, CL);
        bus.ret_i         = has(v.ctl, RT);
        bus.flush_pc_i    = v.ft;
        bus.redirect_pc_i = v.t;
        bus.call_pc_i     = v.t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        v;
        logic [37:0] e;
        logic [31:0] t;

        rst = 1'b1;
        bus.start_i = 0; bus.hazard_i = 0; bus.hold_i = 0; bus.halt_i = 0; bus.flush_i = 0;
        bus.redirect_i = 0; bus.call_i = 0; bus.ret_i = 0;
        bus.flush_pc_i = '0; bus.redirect_pc_i = '0; bus.call_pc_i = '0;
        m_state = IDLE; m_pc = RESET_VEC; m_valid = 0; m_miss = 0; m_mis = 0;

        // Reset, idle behaviour, start, hazard stall.
        add(RS,        0, 0, 32'h100, 0, 0, 0, 0, IDLE);
        add(9'h000,    0, 0, 32'h100, 0, 0, 0, 0, IDLE);
        add(FL,  32'h800, 0, 32'h100, 0, 0, 0, 0, IDLE);
        add(ST,        0, 0, 32'h100, 1, 0, 0, 0, RUN);
        add(ST,        0, 0, 32'h104, 1, 0, 0, 0, RUN);
        add(ST,        0, 0, 32'h108, 1, 0, 0, 0, RUN);
        add(ST|HZ,     0, 0, 32'h108, 1, 0, 0, 0, RUN);
        add(ST|HZ,     0, 0, 32'h108, 1, 0, 0, 0, RUN);
        add(ST,        0, 0, 32'h10C, 1, 0, 0, 0, RUN);
        // Flush beats hold and redirect and clears the stack.
        add(ST|CL,     0, 32'h200, 32'h200, 1, 1, 0, 0, RUN);
        add(ST|HD|FL|RD, 32'h800, 32'h900, 32'h800, 1, 0, 0, 0, RUN);
        add(ST,        0, 0, 32'h804, 1, 0, 0, 0, RUN);
        // Nested call/return, empty-stack return, call+ret together, stalled calls.
        add(ST|RD,     0, 32'h200, 32'h200, 1, 0, 0, 0, RUN);
        add(ST|CL,     0, 32'h400, 32'h400, 1, 1, 0, 0, RUN);
        add(ST|CL,     0, 32'h500, 32'h500, 1, 2, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h404, 1, 1, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h204, 1, 0, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h208, 1, 0, 1, 0, RUN);
        add(ST,        0, 0, 32'h20C, 1, 0, 0, 0, RUN);
        add(ST|CL|RT,  0, 32'h600, 32'h600, 1, 1, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h210, 1, 0, 0, 0, RUN);
        add(ST|HZ|CL,  0, 32'h700, 32'h210, 1, 0, 0, 0, RUN);
        add(CL,        0, 32'h700, 32'h210, 1, 0, 0, 0, RUN);
        // Five calls into a four-entry stack, then drain past empty.
        add(ST|CL,     0, 32'h1000, 32'h1000, 1, 1, 0, 0, RUN);
        add(ST|CL,     0, 32'h2000, 32'h2000, 1, 2, 0, 0, RUN);
        add(ST|CL,     0, 32'h3000, 32'h3000, 1, 3, 0, 0, RUN);
        add(ST|CL,     0, 32'h4000, 32'h4000, 1, 4, 0, 0, RUN);
        add(ST|CL,     0, 32'h5000, 32'h5000, 1, 4, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h4004, 1, 3, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h3004, 1, 2, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h2004, 1, 1, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h1004, 1, 0, 0, 0, RUN);
        add(ST|RT,     0, 0, 32'h1008, 1, 0, 1, 0, RUN);
        // Wrap-around and misaligned targets.
        add(ST|RD,     0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0, RUN);
        add(ST,        0, 0, 32'h0, 1, 0, 0, 0, RUN);
        add(ST|RD,     0, 32'h302, 32'h300, 1, 0, 0, 1, RUN);
        add(ST,        0, 0, 32'h304, 1, 0, 0, 0, RUN);
        add(ST|CL,     0, 32'h503, 32'h500, 1, 1, 0, 1, RUN);
        add(ST|RT,     0, 0, 32'h308, 1, 0, 0, 0, RUN);
        // Halt, resume by flush, reset mid-run with a pending redirect.
        add(ST|HT,     0, 0, 32'h308, 0, 0, 0, 0, HALT);
        add(ST,        0, 0, 32'h308, 0, 0, 0, 0, HALT);
        add(ST|RD,     0, 32'h900, 32'h308, 0, 0, 0, 0, HALT);
        add(ST|FL, 32'h40, 0, 32'h40, 1, 0, 0, 0, RUN);
        add(ST,        0, 0, 32'h44, 1, 0, 0, 0, RUN);
        add(ST|HT|FL, 32'h80, 0, 32'h80, 1, 0, 0, 0, RUN);
        add(ST|CL,     0, 32'hA00, 32'hA00, 1, 1, 0, 0, RUN);
        add(RS|ST|RD,  0, 32'h900, 32'h100, 0, 0, 0, 0, IDLE);
        add(ST,        0, 0, 32'h100, 1, 0, 0, 0, RUN);
        add(ST|FL, 32'h8002, 0, 32'h8000, 1, 0, 0, 1, RUN);

        for (int i = 0; i < vecs.size(); i++) begin
            model_step(vecs[i]);
            apply(vecs[i]);
            chk($sformatf("vec%0d pc", i),    bus.pc_o,        vecs[i].exp_pc);
            chk($sformatf("vec%0d valid", i), bus.pc_valid_o,  vecs[i].exp_v);
            chk($sformatf("vec%0d count", i), bus.ras_count_o, vecs[i].exp_cnt);
            chk($sformatf("vec%0d miss", i),  bus.ras_miss_o,  vecs[i].exp_miss);
            chk($sformatf("vec%0d misal", i), bus.misalign_o,  vecs[i].exp_mis);
            chk($sformatf("vec%0d state", i), 32'(state),      32'(vecs[i].exp_st));
        end

        for (int i = 0; i < 2000; i++) begin
            v.ctl = '0;
            if ($urandom_range(0, 199) == 0)  v.ctl |= RS;
            if ($urandom_range(0, 99) < 92)   v.ctl |= ST;
            if ($urandom_range(0, 99) < 8)    v.ctl |= HZ;
            if ($urandom_range(0, 99) < 8)    v.ctl |= HD;
            if ($urandom_range(0, 99) < 2)    v.ctl |= HT;
            if ($urandom_range(0, 99) < 5)    v.ctl |= FL;
            if ($urandom_range(0, 99) < 12)   v.ctl |= RD;
            if ($urandom_range(0, 99) < 22)   v.ctl |= CL;
            if ($urandom_range(0, 99) < 28)   v.ctl |= RT;
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
            v.t  = t;
            v.ft = $urandom() & 32'h0000_FFFF;
            v.exp_pc = '0; v.exp_v = 0; v.exp_cnt = '0; v.exp_miss = 0; v.exp_mis = 0; v.exp_st = IDLE;
            model_step(v);
            exp_q.push_back({m_pc, m_valid, 3'(m_ras.size()), m_miss, m_mis});
            apply(v);
            e = exp_q.pop_front();
            chk($sformatf("rnd%0d pc", i),    bus.pc_o,        e[37:6]);
            chk($sformatf("rnd%0d valid", i), bus.pc_valid_o,  e[5]);
            chk($sformatf("rnd%0d count", i), bus.ras_count_o, e[4:2]);
            chk($sformatf("rnd%0d miss", i),  bus.ras_miss_o,  e[1]);
            chk($sformatf("rnd%0d misal", i), bus.misalign_o,  e[0]);
            chk($sformatf("rnd%0d state", i), 32'(state),      32'(m_state));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator for the pipelined CPU. It replaces the fixed 32-bit PC register. It adds:
- a configurable reset vector and instruction size;
- a run/halt state machine;
- prioritised redirect sources (flush, branch/jump, call, return);
- a circular return-address stack (RAS).

It sits at the head of IF and drives the instruction-memory address and the IF/ID PC field.

## Interface
- XLEN, 32, PC width in bits
- RESET_VEC, 0, PC value loaded by reset (XLEN bits)
- INST_BYTES, 4, sequential increment; power of two
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous and active-high
- start_i  in  1  CPU enable; when low the PC holds
- hazard_i  in  1  load-use stall from the hazard unit; PC holds
- hold_i  in  1  memory-wait stall; PC holds
- halt_i  in  1  halt request (RUN→HALT)
- flush_i  in  1  exception/mispredict flush; overrides stalls
- flush_pc_i  in  XLEN  flush target
- redirect_i  in  1  taken branch/jump from ID
- redirect_pc_i  in  XLEN  branch/jump target
- call_i  in  1  call instruction in ID; pushes a return address
- call_pc_i  in  XLEN  call target
- ret_i  in  1  return instruction in ID; pops the RAS
- pc_o  out  XLEN  current fetch PC
- pc_valid_o  out  1  pc_o is a fetch request
- ras_count_o  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_miss_o  out  1  one-cycle pulse: return with an empty RAS
- misalign_o  out  1  one-cycle pulse: accepted target had nonzero low bits

## Operation

**States**
- IDLE: after reset; pc_o holds.
- RUN: when start_i=1, pc_o updates each cycle.
- HALT: pc_o holds; pc_valid_o=0.

**Transitions**
- IDLE→RUN on start_i=1. No PC update on that edge.
- RUN→HALT on halt_i=1 when flush_i=0.
- HALT→RUN only on flush_i=1; PC loads flush_pc_i.
- In IDLE, flush_i is ignored.

**Next PC in RUN**, first match wins:
1. flush_i → flush_pc_i. The RAS is cleared (count=0).
2. start_i=0, or hazard_i, or hold_i → hold. Requests from ID are not accepted; ID must hold them asserted.
3. redirect_i → redirect_pc_i.
4. call_i → call_pc_i. Push pc_o+INST_BYTES.
5. ret_i with RAS non-empty → pop top. With RAS empty → pc_o+INST_BYTES, and ras_miss_o=1.
6. Otherwise → pc_o+INST_BYTES.

**Arithmetic and alignment**
- The sum is modulo 2^XLEN; all-ones+INST_BYTES wraps to 0 silently.
- Any loaded target has its low $clog2(INST_BYTES) bits forced to 0.
- misalign_o pulses if those bits were nonzero.

**RAS**
- Circular buffer with a top pointer.
- Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
- Pop decrements the count.
- call_i and ret_i together: call wins, ret is ignored.
- Rejected or held requests never touch the RAS.

## Timing
- **Reset** (rst_i=1 at a posedge):
  - pc_o=RESET_VEC, state=IDLE;
  - pc_valid_o=0, ras_count_o=0;
  - ras_miss_o=0, misalign_o=0;
  - RAS contents don't-care.
- Reset mid-operation behaves identically and discards any pending redirect.
- pc_valid_o=1 exactly when state=RUN.
- **Registered outputs**: every output is a register. An event sampled at edge N is visible after edge N, i.e. one-cycle latency.
- A pop's return value equals the entry pushed by the most recent unmatched call, including when push and pop occur on consecutive cycles.
- ras_miss_o and misalign_o are high for exactly the one cycle after the causing edge.

## Structure
- Package pc_gen_pkg holds:
  - state enum: IDLE, RUN, HALT;
  - next-PC select enum: HOLD, FLUSH, REDIR, CALL, RET, SEQ;
  - a function aligning a target to INST_BYTES.
- Sub-module pc_ras (parameters XLEN, RAS_DEPTH): push/pop/clear inputs, top and count outputs. It resolves overwrite-on-full internally.
- pc_gen holds the FSM, the priority mux and the PC register.

## Test plan
Parameters: XLEN=32, RESET_VEC=0x100, INST_BYTES=4, RAS_DEPTH=4.
- Reset → start_i=1 → pc_o=0x100 (valid=1 after first edge), then 0x104, 0x108. Hazard_i for 2 cycles → pc_o stays at 0x108; releasing it → 0x10C.
- Same cycle: hold_i=1, flush_i=1, flush_pc_i=0x800, redirect_i=1 → next pc_o=0x800, ras_count_o=0. Redirect is not taken.
- Call at pc=0x200 to 0x400, call at 0x400 to 0x500, then ret, ret → pc_o sequence 0x400, 0x500, 0x404, 0x204.
- 5 calls with RAS_DEPTH=4 → count saturates at 4; 4 returns pop the last 4 addresses; a 5th return → ras_miss_o pulse and pc_o+4.
- pc_o=0xFFFFFFFC sequential → pc_o=0x0. redirect_pc_i=0x302 → pc_o=0x300 and a misalign_o pulse.
- halt_i in RUN → valid=0, pc_o frozen; flush_i with flush_pc_i=0x40 → RUN, pc_o=0x40. rst_i mid-run → pc_o=0x100, IDLE.
